// File: rtl/interrupt_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder_pkg
// Description : Shared FSM state encoding and processor-state field layout
//               for the interrupt responder.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    localparam logic [31:0] PSTATE_RST_VALUE = 32'hF00000FF;
    localparam int          GIE_BIT          = 0;
    localparam int          ID_LSB           = 1;
    localparam int          ID_MSB           = 5;
    localparam logic [4:0]  NO_ID            = 5'h1F;

endpackage : interrupt_responder_pkg
`default_nettype wire

// File: rtl/interrupt_responder_stack.sv
`default_nettype none
// ============================================================================
// Module      : int_save_stack
// Description : DEPTH-entry LIFO holding {p_state, pc} frames of nested
//               interrupts; top entry is readable combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module int_save_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [2:0]       count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [2:0]       count_q;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = count_q[AW-1:0];
    assign w_rd_idx = AW'(count_q - 3'd1);
    assign full_o   = (count_q == 3'(DEPTH));
    assign empty_o  = (count_q == 3'd0);
    assign count_o  = count_q;
    // Guarded so an empty stack never presents a stale frame.
    assign top_o    = empty_o ? '0 : mem_q[w_rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[w_wr_idx] <= data_i;
            count_q         <= count_q + 3'd1;
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - 3'd1;
        end
    end

endmodule : int_save_stack
`default_nettype wire

// File: rtl/interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder
// Description : Takes filtered interrupt requests, acknowledges them, offers
//               the vector to the core and unwinds nesting on reti.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_responder
    import interrupt_responder_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] PSTATE_RST = PSTATE_RST_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_flag,
    input  logic [4:0]  int_ID,
    input  logic [31:0] ivt_addr,
    input  logic [31:0] pc_in,
    input  logic        reti,
    input  logic        vec_ready,
    output logic        ack_start,
    output logic [4:0]  ack_start_id,
    output logic        ack_end,
    output logic [4:0]  ack_end_id,
    output logic [31:0] p_state,
    output logic        vec_valid,
    output logic [31:0] vec_addr,
    output logic        ret_valid,
    output logic [31:0] ret_pc,
    output logic [2:0]  depth,
    output logic        err
);

    state_t      state_q,  state_d;
    logic [4:0]  id_q,     id_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] pstate_q, pstate_d;
    logic [4:0]  end_id_q, end_id_d;
    logic [31:0] retpc_q,  retpc_d;
    logic        err_q,    err_d;

    logic        w_push;
    logic        w_pop;
    logic [63:0] w_top;
    logic        w_full;
    logic        w_empty;

    int_save_stack #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  ({pstate_q, pc_in}),
        .top_o   (w_top),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (depth)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            id_q     <= 5'd0;
            addr_q   <= 32'd0;
            pstate_q <= PSTATE_RST;
            end_id_q <= 5'd0;
            retpc_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            pstate_q <= pstate_d;
            end_id_q <= end_id_d;
            retpc_q  <= retpc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        pstate_d = pstate_q;
        end_id_d = end_id_q;
        retpc_d  = retpc_q;
        err_d    = err_q;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        // Any reti that cannot start a RETURN is dropped and flagged.
        if (reti && (state_q != ST_IDLE || w_empty)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (reti) begin
                    if (!w_empty) begin
                        state_d  = ST_RETURN;
                        end_id_d = pstate_q[ID_MSB:ID_LSB];
                        retpc_d  = w_top[31:0];
                    end
                end else if (int_flag && pstate_q[GIE_BIT] && !w_full) begin
                    state_d = ST_ACK;
                    id_d    = int_ID;
                    addr_d  = ivt_addr;
                end
            end
            ST_ACK: begin
                w_push                     = 1'b1;
                pstate_d[GIE_BIT]          = 1'b0;
                pstate_d[ID_MSB:ID_LSB]    = id_q;
                state_d                    = ST_VECTOR;
            end
            ST_VECTOR: begin
                if (vec_ready) begin
                    // Stack already holds this frame, so full means max nesting.
                    pstate_d[GIE_BIT] = !w_full;
                    state_d           = ST_IDLE;
                end
            end
            ST_RETURN: begin
                w_pop    = 1'b1;
                pstate_d = w_top[63:32];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_start    = (state_q == ST_ACK);
    assign ack_start_id = id_q;
    assign ack_end      = (state_q == ST_RETURN);
    assign ack_end_id   = end_id_q;
    assign ret_valid    = (state_q == ST_RETURN);
    assign ret_pc       = retpc_q;
    assign vec_valid    = (state_q == ST_VECTOR);
    assign vec_addr     = addr_q;
    assign p_state      = pstate_q;
    assign err          = err_q;

endmodule : interrupt_responder
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_responder
// Description : Self-checking bench; a queue-based model of nested service
//               frames predicts acks, vectors, return PCs and p_state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] PRST  = 32'hF00000FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_flag;
    logic [4:0]  int_ID;
    logic [31:0] ivt_addr;
    logic [31:0] pc_in;
    logic        reti;
    logic        vec_ready;
    logic        ack_start;
    logic [4:0]  ack_start_id;
    logic        ack_end;
    logic [4:0]  ack_end_id;
    logic [31:0] p_state;
    logic        vec_valid;
    logic [31:0] vec_addr;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [2:0]  depth;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one frame {p_state, pc} per active nesting level.
    logic [63:0] m_stack [$];
    logic [31:0] m_pstate;
    logic        m_err;
    logic [4:0]  m_start_id;
    logic [4:0]  m_end_id;

    interrupt_responder #(
        .DEPTH      (DEPTH),
        .PSTATE_RST (PRST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .int_flag     (int_flag),
        .int_ID       (int_ID),
        .ivt_addr     (ivt_addr),
        .pc_in        (pc_in),
        .reti         (reti),
        .vec_ready    (vec_ready),
        .ack_start    (ack_start),
        .ack_start_id (ack_start_id),
        .ack_end      (ack_end),
        .ack_end_id   (ack_end_id),
        .p_state      (p_state),
        .vec_valid    (vec_valid),
        .vec_addr     (vec_addr),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .depth        (depth),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, ".p_state"}, p_state, m_pstate);
        check({tag, ".depth"}, depth, m_stack.size());
        check({tag, ".err"}, err, m_err);
        check({tag, ".ack_start"}, ack_start, 0);
        check({tag, ".ack_end"}, ack_end, 0);
        check({tag, ".vec_valid"}, vec_valid, 0);
        check({tag, ".ack_start_id"}, ack_start_id, m_start_id);
        check({tag, ".ack_end_id"}, ack_end_id, m_end_id);
    endtask

    task automatic do_reset();
        rst = 1'b0; int_flag = 1'b0; int_ID = '0; ivt_addr = '0; pc_in = '0;
        reti = 1'b0; vec_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_stack.delete();
        m_pstate = PRST; m_err = 1'b0; m_start_id = '0; m_end_id = '0;
        @(negedge clk);
    endtask

    // Full entry handshake; starts and ends at a negedge with the DUT idle.
    task automatic enter(input logic [4:0] id, input logic [31:0] addr,
                         input logic [31:0] pc, input int stall);
        int_flag = 1'b1; int_ID = id; ivt_addr = addr; pc_in = pc;
        @(negedge clk);
        check("entry.ack_start", ack_start, 1);
        check("entry.ack_start_id", ack_start_id, id);
        check("entry.vec_valid_early", vec_valid, 0);
        check("entry.ack_end_excl", ack_end, 0);
        int_flag = 1'b0; int_ID = 5'($urandom); ivt_addr = $urandom;
        m_stack.push_back({m_pstate, pc});
        m_pstate[0] = 1'b0; m_pstate[5:1] = id; m_start_id = id;
        @(negedge clk);
        pc_in = $urandom;
        check("entry.vec_valid", vec_valid, 1);
        check("entry.vec_addr", vec_addr, addr);
        check("entry.ack_start_done", ack_start, 0);
        check("entry.p_state", p_state, m_pstate);
        check("entry.depth", depth, m_stack.size());
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("entry.vec_hold", vec_valid, 1);
        end
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        m_pstate[0] = (m_stack.size() < DEPTH);
        check_idle_state("entry.done");
    endtask

    task automatic do_reti();
        logic [63:0] fr;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        if (m_stack.size() > 0) begin
            fr = m_stack.pop_back();
            m_end_id = m_pstate[5:1];
            check("reti.ack_end", ack_end, 1);
            check("reti.ack_end_id", ack_end_id, m_end_id);
            check("reti.ret_valid", ret_valid, 1);
            check("reti.ret_pc", ret_pc, fr[31:0]);
            check("reti.ack_start_excl", ack_start, 0);
            m_pstate = fr[63:32];
        end else begin
            m_err = 1'b1;
            check("reti0.ack_end", ack_end, 0);
            check("reti0.ret_valid", ret_valid, 0);
        end
        @(negedge clk);
        check_idle_state("reti.done");
    endtask

    task automatic blocked_request();
        int_flag = 1'b1; int_ID = 5'($urandom_range(0, 30)); ivt_addr = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("blocked.ack_start", ack_start, 0);
            check("blocked.vec_valid", vec_valid, 0);
        end
        int_flag = 1'b0;
        check("blocked.depth", depth, DEPTH);
        check("blocked.gie", p_state[0], 0);
    endtask

    initial begin
        do_reset();
        check_idle_state("reset");
        check("reset.p_state_abs", p_state, 32'hF00000FF);
        check("reset.vec_addr", vec_addr, 0);
        check("reset.ret_pc", ret_pc, 0);
        check("reset.ret_valid", ret_valid, 0);

        // Single entry then nested entry and LIFO unwind.
        enter(5'd2, 32'd200, 32'h40, 1);
        check("single.id", p_state[5:1], 2);
        enter(5'd5, 32'h1234, 32'h80, 0);
        do_reti();
        check("nest.ret_id5", ack_end_id, 5);
        do_reti();
        check("nest.ret_id2", ack_end_id, 2);
        check("nest.final_pstate", p_state, 32'hF00000FF);

        // Fill to maximum nesting.
        for (int i = 0; i < DEPTH; i++) begin
            enter(5'($urandom_range(0, 30)), $urandom, $urandom, $urandom_range(0, 2));
        end
        check("full.depth", depth, DEPTH);
        check("full.gie", p_state[0], 0);
        blocked_request();
        for (int i = 0; i < DEPTH; i++) do_reti();

        // reti wins over a simultaneous request.
        enter(5'd7, 32'h700, 32'h77, 0);
        reti = 1'b1; int_flag = 1'b1; int_ID = 5'd9; ivt_addr = 32'h900; pc_in = 32'h99;
        @(negedge clk);
        reti = 1'b0;
        check("prio.ack_end", ack_end, 1);
        check("prio.ack_start", ack_start, 0);
        check("prio.ack_end_id", ack_end_id, 7);
        check("prio.ret_pc", ret_pc, 32'h77);
        void'(m_stack.pop_back());
        m_end_id = 5'd7; m_pstate = PRST;
        @(negedge clk);
        check("prio.after_ack_start", ack_start, 0);
        check("prio.after_depth", depth, 0);
        enter(5'd9, 32'h900, 32'h99, 0);
        do_reti();

        // Underflowing reti sets a sticky error.
        check("err.before", err, 0);
        do_reti();
        check("err.set", err, 1);
        repeat (3) @(negedge clk);
        check("err.sticky", err, 1);

        // Randomized mix of entries, returns and blocked requests.
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 3);
            if (m_stack.size() == DEPTH && r == 3) blocked_request();
            else if (m_stack.size() < DEPTH && r < 2)
                enter(5'($urandom_range(0, 30)), $urandom, $urandom, $urandom_range(0, 3));
            else do_reti();
        end
        check("rand.err_sticky", err, 1);

        // Reset while a vector is being offered.
        while (m_stack.size() > 0) do_reti();
        int_flag = 1'b1; int_ID = 5'd3; ivt_addr = 32'h300; pc_in = 32'h30;
        @(negedge clk);
        int_flag = 1'b0;
        @(negedge clk);
        check("rstvec.vec_valid", vec_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rstvec.ack_end", ack_end, 0);
        check("rstvec.vec_valid_off", vec_valid, 0);
        rst = 1'b1;
        m_stack.delete();
        m_pstate = PRST; m_err = 1'b0; m_start_id = '0; m_end_id = '0;
        @(negedge clk);
        check_idle_state("rstvec.idle");
        check("rstvec.vec_addr", vec_addr, 0);
        enter(5'd4, 32'h444, 32'h44, 0);
        do_reti();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_interrupt_responder
`default_nettype wire
